alu_unit: RTL and testbench
===========================

# alu_unit

Registered 32-bit integer ALU for the processor datapath's execute stage. It performs ADD, SUB, AND, ORR, EOR, MUL, SMULL and UMULL on two 32-bit operands, selected by a 3-bit control code. It returns a 32-bit primary result, a 32-bit extra result (upper product word) and NZCV condition flags. All outputs are registered one clock after the operands are applied.

## Interface
Parameters: none (data width fixed at 32).

Clocking and reset: one clock; reset is asynchronous and active-low.

- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- ALUControl  input  3  operation select
- A  input  32  operand A
- B  input  32  operand B
- ALUFlags  output  4  {N, Z, C, V}, registered
- Result  output  32  primary result (low product word for multiplies), registered
- ResultExtra  output  32  upper 32 bits of the 64-bit product for codes 100/110/111; 0 otherwise; registered

## Operation
Encoding of ALUControl:
- 000 ADD: Result = A+B. C = carry out of bit 31. V = (A[31]==B[31]) && (Result[31]!=A[31]).
- 001 SUB: Result = A + ~B + 1. C = carry out (1 = no borrow). V = (A[31]!=B[31]) && (Result[31]!=A[31]).
- 010 AND: A & B. C=0, V=0.
- 011 ORR: A | B. C=0, V=0.
- 101 EOR: A ^ B. C=0, V=0.
- 100 MUL: 64-bit unsigned product P = A*B. Result = P[31:0], ResultExtra = P[63:32] (nonzero = unsigned overflow indicator).
- 110 SMULL: 64-bit two's-complement product of signed A and signed B. Result = low word, ResultExtra = high word.
- 111 UMULL: 64-bit unsigned product. Result = low word, ResultExtra = high word.

Flags:
- N, Z for 000–011 and 101: N = Result[31]; Z = (Result==0).
- N, Z for MUL: taken from the 32-bit Result only.
- N, Z for SMULL/UMULL: taken from the full 64-bit value. N = ResultExtra[31]; Z = ({ResultExtra,Result}==0).
- C and V are 0 for all multiply codes.
- ResultExtra is 0 for non-multiply codes.
- All arithmetic wraps modulo 2^32 (2^64 for long products). No saturation.

## Timing
- Combinational compute, then one register stage. Operands and code sampled on rising clk edge N appear on the outputs after edge N; latency is 1 cycle.
- Throughput is one operation per cycle. There is no handshake: a new operation is accepted every cycle, back-to-back.
- Reset: while reset_n=0, Result=0, ResultExtra=0 and ALUFlags=4'b0000, asynchronously and immediately.
- First capture after reset occurs on the first rising edge with reset_n=1.
- Reset asserted mid-stream discards the in-flight result.
- Changing ALUControl between edges has no effect until the next edge.

## Configuration
- Macro ALU_LONG_MUL_EN.
- Defined: SMULL (110) and UMULL (111) behave as specified above.
- Undefined: the long multipliers are omitted. Codes 110 and 111 behave exactly as MUL (100): unsigned product, Result = low word, ResultExtra = high word, N/Z from Result, C=V=0.
- All other codes are unaffected by the macro.

## Test plan
- Reset: hold reset_n=0 with any inputs -> Result=00000000, ResultExtra=00000000, ALUFlags=0000. Release reset, apply ADD 1+2 -> after the next edge Result=00000003, flags 0000.
- MUL: A=fffffffe (-2), B=00000003 -> Result=fffffffa, ResultExtra=00000002, ALUFlags=1000.
- SMULL (macro defined): A=fffffffb (-5), B=0000000a -> Result=ffffffce, ResultExtra=ffffffff, ALUFlags=1000.
- UMULL: A=0000000a, B=0000002d -> Result=000001c2, ResultExtra=00000000, ALUFlags=0000.
- ADD/SUB flags:
  - ADD 7fffffff+00000001 -> Result=80000000, flags 1001.
  - SUB 5-5 -> Result=00000000, flags 0110.
  - SUB 0-1 -> Result=ffffffff, flags 1000.
- Logic and pipelining: back-to-back AND f0f0f0f0&ff00ff00, ORR 0|0, EOR aaaaaaaa^ffffffff on consecutive cycles -> outputs f000f000 (flags 1000), 00000000 (flags 0100), 55555555 (flags 0000), each one cycle after its input.

Source files
------------

// File: rtl/alu_unit.sv
// ============================================================================
// alu_unit
// ----------------------------------------------------------------------------
// Registered 32-bit integer ALU for the execute stage. The operation is
// computed combinationally from the operands and the control code, then
// captured in one register stage. Latency is one clock and throughput is one
// operation per clock.
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset; clears all outputs at once
//   ALUControl   3-bit operation select
//                  000 ADD   001 SUB   010 AND   011 ORR
//                  101 EOR   100 MUL   110 SMULL 111 UMULL
//   A, B         32-bit operands
//   ALUFlags     registered {N, Z, C, V}
//   Result       registered primary result (low product word for multiplies)
//   ResultExtra  registered upper product word for 100/110/111, else 0
//
// Configuration
//   ALU_LONG_MUL_EN  When defined, SMULL (110) and UMULL (111) produce the
//                    full 64-bit signed or unsigned product, and their N/Z
//                    flags come from the whole 64-bit value. When undefined,
//                    the long multipliers are omitted and 110/111 behave
//                    exactly like MUL (100).
// ============================================================================
module alu_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  ALUControl,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [3:0]  ALUFlags,
    output logic [31:0] Result,
    output logic [31:0] ResultExtra
);

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_ORR   = 3'b011;
    localparam logic [2:0] OP_MUL   = 3'b100;
    localparam logic [2:0] OP_EOR   = 3'b101;
    localparam logic [2:0] OP_SMULL = 3'b110;
    localparam logic [2:0] OP_UMULL = 3'b111;

    // ------------------------------------------------------------------
    // Shared adder. SUB is A + ~B + 1, so one adder serves both ADD and
    // SUB. The carry out is then "no borrow" for SUB.
    // ------------------------------------------------------------------
    logic        sub_sel;
    logic [31:0] b_addend;
    logic [32:0] sum_full;
    logic [31:0] sum;
    logic        sum_carry;
    logic        sum_overflow;

    assign sub_sel   = (ALUControl == OP_SUB);
    assign b_addend  = sub_sel ? ~B : B;
    assign sum_full  = {1'b0, A} + {1'b0, b_addend} + {32'd0, sub_sel};
    assign sum       = sum_full[31:0];
    assign sum_carry = sum_full[32];

    // Overflow is checked against the addend actually used. For SUB the
    // addend is ~B, so "A and addend have the same sign" is the same as
    // "A and B have different signs".
    assign sum_overflow = (A[31] == b_addend[31]) && (sum[31] != A[31]);

    // ------------------------------------------------------------------
    // Bitwise logic unit, built one bit slice at a time.
    // ------------------------------------------------------------------
    logic [31:0] and_res;
    logic [31:0] orr_res;
    logic [31:0] eor_res;

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_logic_slice
            assign and_res[gi] = A[gi] & B[gi];
            assign orr_res[gi] = A[gi] | B[gi];
            assign eor_res[gi] = A[gi] ^ B[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Multipliers. The unsigned 64-bit product is always present because
    // MUL needs it.
    // ------------------------------------------------------------------
    logic [63:0] a_zx;
    logic [63:0] b_zx;
    logic [63:0] prod_u;

    assign a_zx   = {32'd0, A};
    assign b_zx   = {32'd0, B};
    assign prod_u = a_zx * b_zx;

`ifdef ALU_LONG_MUL_EN
    // The low 64 bits of a product of sign-extended operands are the
    // two's-complement product. No signed arithmetic types are needed.
    logic [63:0] a_sx;
    logic [63:0] b_sx;
    logic [63:0] prod_s;

    assign a_sx   = {{32{A[31]}}, A};
    assign b_sx   = {{32{B[31]}}, B};
    assign prod_s = a_sx * b_sx;
`endif

    // ------------------------------------------------------------------
    // Result and flag selection
    // ------------------------------------------------------------------
    logic [31:0] result_next;
    logic [31:0] extra_next;
    logic        n_next;
    logic        z_next;
    logic        c_next;
    logic        v_next;

    always_comb begin
        result_next = 32'd0;
        extra_next  = 32'd0;
        n_next      = 1'b0;
        z_next      = 1'b0;
        c_next      = 1'b0;
        v_next      = 1'b0;

        case (ALUControl)
            OP_ADD, OP_SUB: begin
                result_next = sum;
                c_next      = sum_carry;
                v_next      = sum_overflow;
                n_next      = sum[31];
                z_next      = (sum == 32'd0);
            end
            OP_AND: begin
                result_next = and_res;
                n_next      = and_res[31];
                z_next      = (and_res == 32'd0);
            end
            OP_ORR: begin
                result_next = orr_res;
                n_next      = orr_res[31];
                z_next      = (orr_res == 32'd0);
            end
            OP_EOR: begin
                result_next = eor_res;
                n_next      = eor_res[31];
                z_next      = (eor_res == 32'd0);
            end
            OP_MUL: begin
                // N/Z come from the low word only. A nonzero upper word
                // signals unsigned overflow.
                result_next = prod_u[31:0];
                extra_next  = prod_u[63:32];
                n_next      = prod_u[31];
                z_next      = (prod_u[31:0] == 32'd0);
            end
`ifdef ALU_LONG_MUL_EN
            OP_SMULL: begin
                // Long products take N/Z from the full 64-bit value.
                result_next = prod_s[31:0];
                extra_next  = prod_s[63:32];
                n_next      = prod_s[63];
                z_next      = (prod_s == 64'd0);
            end
            OP_UMULL: begin
                result_next = prod_u[31:0];
                extra_next  = prod_u[63:32];
                n_next      = prod_u[63];
                z_next      = (prod_u == 64'd0);
            end
`else
            OP_SMULL, OP_UMULL: begin
                // Without the long multipliers these codes are aliases of MUL.
                result_next = prod_u[31:0];
                extra_next  = prod_u[63:32];
                n_next      = prod_u[31];
                z_next      = (prod_u[31:0] == 32'd0);
            end
`endif
            default: begin
                result_next = 32'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output register stage
    // ------------------------------------------------------------------
    logic [31:0] result_reg;
    logic [31:0] extra_reg;
    logic [3:0]  flags_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_reg <= 32'd0;
            extra_reg  <= 32'd0;
            flags_reg  <= 4'b0000;
        end else begin
            result_reg <= result_next;
            extra_reg  <= extra_next;
            flags_reg  <= {n_next, z_next, c_next, v_next};
        end
    end

    assign Result      = result_reg;
    assign ResultExtra = extra_reg;
    assign ALUFlags    = flags_reg;

endmodule

// File: tb/tb_alu_unit.sv
// ============================================================================
// tb_alu_unit
// ----------------------------------------------------------------------------
// Self-checking bench for alu_unit. Directed steps from the test plan are
// followed by randomized operations checked against an arithmetic reference
// model. Each check compares the packed value {ALUFlags, ResultExtra, Result}.
// The bench follows the same ALU_LONG_MUL_EN define as the design.
// ============================================================================
module tb_alu_unit;

    logic        clk;
    logic        reset_n;
    logic [2:0]  ALUControl;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALUFlags;
    logic [31:0] Result;
    logic [31:0] ResultExtra;

    int checks;
    int failures;

    alu_unit dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ALUControl  (ALUControl),
        .A           (A),
        .B           (B),
        .ALUFlags    (ALUFlags),
        .Result      (Result),
        .ResultExtra (ResultExtra)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Reference model, written directly from the arithmetic rules.
    // It returns {N, Z, C, V, extra, result}.
    function automatic logic [67:0] model(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint unsigned ua, ub, p;
        longint          sa, sb;
        logic [31:0] res, ext;
        logic n, z, c, v;
        bit long_en;
`ifdef ALU_LONG_MUL_EN
        long_en = 1'b1;
`else
        long_en = 1'b0;
`endif
        ua = a; ub = b;
        sa = $signed(a); sb = $signed(b);
        res = 0; ext = 0; n = 0; z = 0; c = 0; v = 0;
        case (op)
            3'b000: begin
                p   = ua + ub;
                res = p[31:0];
                c   = p[32];
                v   = (a[31] == b[31]) && (res[31] != a[31]);
            end
            3'b001: begin
                res = a - b;
                c   = (a >= b);
                v   = (a[31] != b[31]) && (res[31] != a[31]);
            end
            3'b010: res = a & b;
            3'b011: res = a | b;
            3'b101: res = a ^ b;
            default: begin
                if (op == 3'b110 && long_en) p = longint'(sa * sb);
                else                          p = ua * ub;
                res = p[31:0];
                ext = p[63:32];
            end
        endcase
        if (long_en && (op == 3'b110 || op == 3'b111)) begin
            n = ext[31];
            z = ({ext, res} == 64'd0);
        end else begin
            n = res[31];
            z = (res == 32'd0);
        end
        return {n, z, c, v, ext, res};
    endfunction

    task automatic check(input string tag, input logic [67:0] expected);
        logic [67:0] observed;
        observed = {ALUFlags, ResultExtra, Result};
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s: observed flags=%b extra=%h result=%h, expected flags=%b extra=%h result=%h",
                   tag, observed[67:64], observed[63:32], observed[31:0],
                   expected[67:64], expected[63:32], expected[31:0]);
        end
    endtask

    // Drive one operation on the falling edge, then sample just after the
    // rising edge that captures it.
    task automatic step(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        ALUControl = op;
        A = a;
        B = b;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hffff_ffff;
            2: return 32'h8000_0000;
            3: return 32'h7fff_ffff;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        checks = 0;
        failures = 0;
        reset_n = 1'b0;
        ALUControl = 3'b001;
        A = 32'hdead_beef;
        B = 32'h1234_5678;

        // Reset holds the outputs at zero regardless of the inputs and clock.
        #3;
        check("reset_async", 68'd0);
        @(posedge clk); #1;
        check("reset_hold", 68'd0);

        // First capture after release
        @(negedge clk);
        reset_n = 1'b1;
        ALUControl = 3'b000; A = 32'd1; B = 32'd2;
        @(posedge clk); #1;
        check("add_1_2", {4'b0000, 32'h0, 32'h0000_0003});

        // Input changes between edges do not reach the outputs.
        ALUControl = 3'b001; A = 32'h0; B = 32'h5;
        #2;
        check("hold_between_edges", {4'b0000, 32'h0, 32'h0000_0003});

        step(3'b100, 32'hffff_fffe, 32'h0000_0003);
        check("mul", {4'b1000, 32'h0000_0002, 32'hffff_fffa});

`ifdef ALU_LONG_MUL_EN
        step(3'b110, 32'hffff_fffb, 32'h0000_000a);
        check("smull", {4'b1000, 32'hffff_ffff, 32'hffff_ffce});
        step(3'b111, 32'h8000_0000, 32'h0000_0002);
        check("umull_64bit_nz", {4'b0000, 32'h0000_0001, 32'h0000_0000});
`else
        step(3'b110, 32'hffff_fffb, 32'h0000_000a);
        check("smull_as_mul", {4'b1000, 32'h0000_0009, 32'hffff_ffce});
        step(3'b111, 32'h8000_0000, 32'h0000_0002);
        check("umull_as_mul", {4'b0100, 32'h0000_0001, 32'h0000_0000});
`endif

        step(3'b111, 32'h0000_000a, 32'h0000_002d);
        check("umull", {4'b0000, 32'h0, 32'h0000_01c2});

        step(3'b000, 32'h7fff_ffff, 32'h0000_0001);
        check("add_ovf", {4'b1001, 32'h0, 32'h8000_0000});
        step(3'b001, 32'd5, 32'd5);
        check("sub_zero", {4'b0110, 32'h0, 32'h0000_0000});
        step(3'b001, 32'd0, 32'd1);
        check("sub_borrow", {4'b1000, 32'h0, 32'hffff_ffff});
        step(3'b000, 32'hffff_ffff, 32'h0000_0001);
        check("add_carry_zero", {4'b0110, 32'h0, 32'h0000_0000});

        // Back-to-back logic ops, one result per cycle
        step(3'b010, 32'hf0f0_f0f0, 32'hff00_ff00);
        check("and", {4'b1000, 32'h0, 32'hf000_f000});
        step(3'b011, 32'h0, 32'h0);
        check("orr", {4'b0100, 32'h0, 32'h0000_0000});
        step(3'b101, 32'haaaa_aaaa, 32'hffff_ffff);
        check("eor", {4'b0000, 32'h0, 32'h5555_5555});

        // A reset asserted mid-stream discards the operation in flight.
        @(negedge clk);
        ALUControl = 3'b000; A = 32'h1; B = 32'h1;
        #2;
        reset_n = 1'b0;
        #1;
        check("reset_midstream", 68'd0);
        @(posedge clk); #1;
        check("reset_discard", 68'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Randomized operations against the model
        for (int i = 0; i < 300; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = pick_operand();
            rb  = pick_operand();
            step(rop, ra, rb);
            check($sformatf("rand%0d_op%0d", i, rop), model(rop, ra, rb));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
